// File: rtl/fetch_sequencer.sv
`default_nettype none
// fetch_sequencer: PC owner, I-memory request sequencer and fetch/decode register.
// Rev 1.0
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        fd_stall,
    input  logic        dec_redirect,
    input  logic [31:0] dec_target,
    input  logic        dec_halt,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic [31:0] fd_instruction,
    output logic [31:0] fd_npc,
    output logic        fd_valid,
    output logic        halted
);

    localparam logic [1:0]  S_FETCH  = 2'd0;
    localparam logic [1:0]  S_DRAIN  = 2'd1;
    localparam logic [1:0]  S_HOLD   = 2'd2;
    localparam logic [1:0]  S_HALTED = 2'd3;
    localparam logic [31:0] C_INC    = 32'(PC_INC);
    localparam logic [31:0] C_ALIGN  = 32'hFFFF_FFFC;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic        r_drain_halt;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_npc;
    logic [31:0] r_fd_instr;
    logic [31:0] r_fd_npc;
    logic        r_fd_valid;

    logic        w_dec_redir_eff;
    logic        w_dec_halt_eff;
    logic        w_redir_ev;
    logic        w_halt_ev;
    logic        w_event;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_req_nxt;
    logic        w_dh_nxt;
    logic        w_buf_load;

    assign w_dec_redir_eff = dec_redirect & ~fd_stall & ~ex_redirect;
    assign w_dec_halt_eff  = dec_halt & ~fd_stall & ~ex_redirect;
    // Halt beats a simultaneous decode redirect; execute beats both.
    assign w_halt_ev  = w_dec_halt_eff;
    assign w_redir_ev = ex_redirect | (w_dec_redir_eff & ~w_dec_halt_eff);
    assign w_event    = w_redir_ev | w_halt_ev;
    assign w_target   = (ex_redirect ? ex_target : dec_target) & C_ALIGN;
    assign w_pc_inc   = r_pc + C_INC;

    assign imemREN  = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign imemaddr = (r_state == S_DRAIN) ? r_req_addr : r_pc;
    assign halted   = (r_state == S_HALTED);

    assign fd_instruction = r_fd_instr;
    assign fd_npc         = r_fd_npc;
    assign fd_valid       = r_fd_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req_nxt   = r_req_addr;
        w_dh_nxt    = r_drain_halt;
        w_buf_load  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_event) begin
                    if (w_redir_ev) w_pc_nxt = w_target;
                    // An outstanding request must keep its address until it completes.
                    if (!ihit) begin
                        w_state_nxt = S_DRAIN;
                        w_req_nxt   = r_pc;
                        w_dh_nxt    = w_halt_ev;
                    end else if (w_halt_ev) begin
                        w_state_nxt = S_HALTED;
                    end
                end else if (ihit) begin
                    w_pc_nxt = w_pc_inc;
                    if (fd_stall) begin
                        w_state_nxt = S_HOLD;
                        w_buf_load  = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (w_event) begin
                    if (w_redir_ev) w_pc_nxt = w_target;
                    w_state_nxt = w_halt_ev ? S_HALTED : S_FETCH;
                end else if (!fd_stall) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (w_redir_ev) begin
                    w_pc_nxt = w_target;
                    w_dh_nxt = 1'b0;
                end else if (w_halt_ev) begin
                    w_dh_nxt = 1'b1;
                end
                if (ihit) w_state_nxt = w_dh_nxt ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                if (ex_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC & C_ALIGN;
            r_req_addr   <= RESET_PC & C_ALIGN;
            r_drain_halt <= 1'b0;
            r_buf_instr  <= 32'h0;
            r_buf_npc    <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_req_addr   <= w_req_nxt;
            r_drain_halt <= w_dh_nxt;
            if (w_buf_load) begin
                r_buf_instr <= imemload;
                r_buf_npc   <= w_pc_inc;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fd_instr <= 32'h0;
            r_fd_npc   <= 32'h0;
            r_fd_valid <= 1'b0;
        end else if (ex_redirect) begin
            r_fd_valid <= 1'b0;
        end else if (fd_stall) begin
            r_fd_valid <= r_fd_valid;
        end else if (w_dec_redir_eff || w_dec_halt_eff) begin
            r_fd_valid <= 1'b0;
        end else if (r_state == S_HOLD) begin
            r_fd_instr <= r_buf_instr;
            r_fd_npc   <= r_buf_npc;
            r_fd_valid <= 1'b1;
        end else if (r_state == S_FETCH && ihit) begin
            r_fd_instr <= imemload;
            r_fd_npc   <= w_pc_inc;
            r_fd_valid <= 1'b1;
        end else begin
            r_fd_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer.
// Rev 1.0
module tb_fetch_sequencer;

    localparam logic [31:0] C_SALT = 32'hC0DE_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        fd_stall = 1'b0;
    logic        dec_redirect = 1'b0;
    logic [31:0] dec_target = 32'h0;
    logic        dec_halt = 1'b0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic [31:0] fd_instruction;
    logic [31:0] fd_npc;
    logic        fd_valid;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb[$];

    fetch_sequencer #(.RESET_PC(32'h0), .PC_INC(4)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .fd_stall(fd_stall),
        .dec_redirect(dec_redirect), .dec_target(dec_target),
        .dec_halt(dec_halt), .ex_redirect(ex_redirect), .ex_target(ex_target),
        .fd_instruction(fd_instruction), .fd_npc(fd_npc),
        .fd_valid(fd_valid), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Memory model: word depends on the address presented.
    assign imemload = imemaddr ^ C_SALT;

    // Decode consumes the FD register at every edge where it is live, unstalled and not flushed.
    always @(negedge CLK) begin
        if (!RST && fd_valid && !fd_stall && !ex_redirect) begin
            logic [63:0] exp;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL fd_unexpected: got instr=%h npc=%h, none expected", fd_instruction, fd_npc);
            end else begin
                exp = sb.pop_front();
                if ({fd_instruction, fd_npc} !== exp) begin
                    miscompares++;
                    $display("FAIL fd_word: got instr=%h npc=%h, expected instr=%h npc=%h",
                             fd_instruction, fd_npc, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        vectors++;
        if (imemREN !== 1'b1 || imemaddr !== a) begin
            miscompares++;
            $display("FAIL fetch_addr: got ren=%b addr=%h, expected ren=1 addr=%h", imemREN, imemaddr, a);
        end
        sb.push_back({a ^ C_SALT, a + 32'd4});
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #3;
        vectors++;
        if ({fd_valid, halted, fd_instruction, fd_npc} !== 66'h0 || imemaddr !== 32'h0 || imemREN !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b h=%b i=%h n=%h a=%h ren=%b, expected all 0 ren=1",
                     fd_valid, halted, fd_instruction, fd_npc, imemaddr, imemREN);
        end
        tick();
        RST = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] pc = 32'h0;
        ihit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_fetch(pc);
            tick();
            pc += 32'd4;
            vectors++;
            if (fd_valid !== 1'b1 || fd_npc !== pc) begin
                miscompares++;
                $display("FAIL seq_fd: got v=%b npc=%h, expected v=1 npc=%h", fd_valid, fd_npc, pc);
            end
        end
        ihit = 1'b0;
        tick();
        tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL seq_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_redirect_drain();
        dec_redirect = 1'b1;
        dec_target   = 32'h100;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (imemREN !== 1'b1 || imemaddr !== 32'h10) begin
                miscompares++;
                $display("FAIL drain_addr: got ren=%b addr=%h, expected ren=1 addr=00000010", imemREN, imemaddr);
            end
            tick();
            dec_redirect = 1'b0;
        end
        ihit = 1'b1;
        tick();
        vectors++;
        if (fd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_drop: got fd_valid=%b, expected 0", fd_valid);
        end
        expect_fetch(32'h100);
        tick();
        vectors++;
        if (fd_valid !== 1'b1 || fd_npc !== 32'h104) begin
            miscompares++;
            $display("FAIL redirect_fd: got v=%b npc=%h, expected v=1 npc=00000104", fd_valid, fd_npc);
        end
        ihit = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        ihit = 1'b1;
        expect_fetch(32'h104);
        tick();
        fd_stall = 1'b1;
        expect_fetch(32'h108);
        tick();
        vectors++;
        if (imemREN !== 1'b0 || fd_valid !== 1'b1 || fd_instruction !== (32'h104 ^ C_SALT)) begin
            miscompares++;
            $display("FAIL stall_hold: got ren=%b v=%b instr=%h, expected ren=0 v=1 instr=%h",
                     imemREN, fd_valid, fd_instruction, 32'h104 ^ C_SALT);
        end
        tick();
        fd_stall = 1'b0;
        vectors++;
        if (imemREN !== 1'b0 || fd_npc !== 32'h108) begin
            miscompares++;
            $display("FAIL stall_hold2: got ren=%b npc=%h, expected ren=0 npc=00000108", imemREN, fd_npc);
        end
        tick();
        vectors++;
        if (fd_valid !== 1'b1 || fd_npc !== 32'h10C) begin
            miscompares++;
            $display("FAIL stall_release: got v=%b npc=%h, expected v=1 npc=0000010c", fd_valid, fd_npc);
        end
        expect_fetch(32'h10C);
        tick();
        ihit = 1'b0;
        tick();
        tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL stall_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_dual_redirect();
        ihit = 1'b1;
        dec_redirect = 1'b1;
        dec_target   = 32'h200;
        ex_redirect  = 1'b1;
        ex_target    = 32'h300;
        tick();
        dec_redirect = 1'b0;
        ex_redirect  = 1'b0;
        vectors++;
        if (fd_valid !== 1'b0 || imemaddr !== 32'h300) begin
            miscompares++;
            $display("FAIL dual_redirect: got v=%b addr=%h, expected v=0 addr=00000300", fd_valid, imemaddr);
        end
        expect_fetch(32'h300);
        tick();
        ihit = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        dec_halt = 1'b1;
        tick();
        dec_halt = 1'b0;
        vectors++;
        if (halted !== 1'b0 || imemREN !== 1'b1 || imemaddr !== 32'h304) begin
            miscompares++;
            $display("FAIL halt_drain: got h=%b ren=%b addr=%h, expected h=0 ren=1 addr=00000304",
                     halted, imemREN, imemaddr);
        end
        ihit = 1'b1;
        tick();
        dec_redirect = 1'b1;
        dec_target   = 32'h500;
        tick();
        dec_redirect = 1'b0;
        vectors++;
        if (halted !== 1'b1 || imemREN !== 1'b0 || fd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halted: got h=%b ren=%b v=%b, expected h=1 ren=0 v=0", halted, imemREN, fd_valid);
        end
        ex_redirect = 1'b1;
        ex_target   = 32'h40;
        ihit        = 1'b0;
        tick();
        ex_redirect = 1'b0;
        vectors++;
        if (halted !== 1'b0 || imemREN !== 1'b1 || imemaddr !== 32'h40) begin
            miscompares++;
            $display("FAIL unhalt: got h=%b ren=%b addr=%h, expected h=0 ren=1 addr=00000040",
                     halted, imemREN, imemaddr);
        end
        ihit = 1'b1;
        expect_fetch(32'h40);
        tick();
        ihit = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        dec_redirect = 1'b1;
        dec_target   = 32'h80;
        tick();
        dec_redirect = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        vectors++;
        if ({fd_valid, halted, fd_instruction, fd_npc} !== 66'h0 || imemaddr !== 32'h0 || imemREN !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b h=%b i=%h n=%h a=%h ren=%b, expected all 0 ren=1",
                     fd_valid, halted, fd_instruction, fd_npc, imemaddr, imemREN);
        end
        #1;
        RST = 1'b0;
        tick();
        ihit = 1'b1;
        expect_fetch(32'h0);
        tick();
        ihit = 1'b0;
        tick();
        ex_redirect = 1'b1;
        ex_target   = 32'h103;
        ihit        = 1'b1;
        tick();
        ex_redirect = 1'b0;
        vectors++;
        if (fd_valid !== 1'b0 || imemaddr !== 32'h100) begin
            miscompares++;
            $display("FAIL ex_align: got v=%b addr=%h, expected v=0 addr=00000100", fd_valid, imemaddr);
        end
        expect_fetch(32'h100);
        tick();
        ihit = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        ex_redirect = 1'b1;
        ex_target   = 32'hFFFF_FFFF;
        tick();
        ex_redirect = 1'b0;
        vectors++;
        if (imemaddr !== 32'h104) begin
            miscompares++;
            $display("FAIL wrap_drain_addr: got %h, expected 00000104", imemaddr);
        end
        ihit = 1'b1;
        tick();
        expect_fetch(32'hFFFF_FFFC);
        tick();
        expect_fetch(32'h0);
        tick();
        ihit = 1'b0;
        tick();
        tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_drain: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_drain();
        test_stall();
        test_dual_redirect();
        test_halt();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the fetch half of the fetch/decode boundary.
- Owns the PC and sequences instruction-memory requests against `ihit`.
- Buffers a returned instruction while decode is stalled, and drives the fetch/decode pipeline register: instruction, next-PC and valid.
- Applies redirects from decode (branch resolved in ID) and execute (late redirect, higher priority), squashes wrong-path fetches, and handles halt.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset; first fetch address.
- PC_INC, 4, sequential PC increment in bytes.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction memory hit; `imemload` valid this cycle.
- imemload  in  32  instruction word returned by memory.
- imemREN  out  1  instruction memory read request.
- imemaddr  out  32  instruction fetch address; bits [1:0] always 00.
- fd_stall  in  1  hazard unit: hold the FD register and the decode stage.
- dec_redirect  in  1  decode resolved a taken branch/jump.
- dec_target  in  32  decode redirect target.
- dec_halt  in  1  decode holds a halt instruction.
- ex_redirect  in  1  execute-stage redirect; flushes FD.
- ex_target  in  32  execute redirect target.
- fd_instruction  out  32  FD register: instruction.
- fd_npc  out  32  FD register: fetch address + PC_INC.
- fd_valid  out  1  FD register holds a live instruction.
- halted  out  1  high while in state HALTED.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = FETCH; buf = 0; drain_halt = 0.
  - fd_instruction = 0, fd_npc = 0, fd_valid = 0, halted = 0.
  - imemREN is combinational from state: it is 1 in the first cycle after reset release.
- State FETCH: imemREN = 1, imemaddr = pc.
- State DRAIN: imemREN = 1, imemaddr = the stale address held in register `req_addr`. Data returned on `ihit` is discarded.
- State HOLD: imemREN = 0. `buf` holds the fetched instruction and its npc.
- State HALTED: imemREN = 0; halted = 1.
- Request stability: while imemREN = 1 and ihit = 0, imemaddr must not change between cycles. Redirects therefore go through DRAIN instead of moving the address.
- Decode-side events are effective only when fd_stall = 0:
  - dec_redirect_eff = dec_redirect & !fd_stall & !ex_redirect.
  - dec_halt_eff = dec_halt & !fd_stall & !ex_redirect.
  - If both are asserted, halt wins.
- ex_redirect overrides everything, including fd_stall.
- Redirect target: new pc = target & ~3.
- Handling of any redirect or halt event by current state:
  - FETCH with ihit = 0 → go to DRAIN; req_addr keeps the old pc.
  - FETCH with ihit = 1 → discard the data, stay in FETCH at the new pc. For halt, go to HALTED.
  - HOLD → discard buf, go to FETCH at the new pc. For halt, go to HALTED.
  - DRAIN → update the pending pc; latest event wins. drain_halt is set by halt and cleared by redirect.
  - HALTED → ex_redirect goes to FETCH at ex_target. dec_* events are ignored.
- DRAIN exit: on ihit, go to HALTED if drain_halt, else FETCH.
- Normal fetch (FETCH, ihit = 1, no event):
  - If fd_stall = 0: load the FD register with imemload and npc = pc + PC_INC; pc += PC_INC; next request issues the next cycle.
  - If fd_stall = 1: buf ← {imemload, pc + PC_INC}; pc += PC_INC; go to HOLD.
- HOLD exit (no event): when fd_stall = 0, load FD from buf, go to FETCH.
- FD register next-value priority, first match wins:
  1. ex_redirect → fd_valid = 0.
  2. fd_stall → hold all fields.
  3. dec_redirect_eff or dec_halt_eff → fd_valid = 0.
  4. HOLD → load buf, fd_valid = 1.
  5. FETCH & ihit → load memory data, fd_valid = 1.
  6. Otherwise → fd_valid = 0; instruction and npc hold their values.
- Arithmetic: pc + PC_INC wraps modulo 2^32.
- Reset asserted mid-request: everything returns to reset values immediately. Any ihit in the following cycles is treated as the reply to the new RESET_PC request.
- Throughput: one instruction per cycle when ihit is held high and there are no stalls.
- Latency: ihit to fd_valid is one edge.

Test Plan:
- Reset release with ihit tied to 1 and imemload = PC → imemaddr sequence 0, 4, 8, 12; fd_valid = 1 from the second cycle; fd_npc = 4, 8, 12.
- ihit = 0 for 3 cycles with dec_redirect (target 0x100) on cycle 1 → imemaddr stays at the old PC until ihit; that data is dropped with fd_valid = 0; next imemaddr = 0x100; fd_npc = 0x104.
- fd_stall high for 2 cycles while ihit = 1 → imemREN drops, buf holds the instruction, FD unchanged. On release FD gets the buffered word, then fetch resumes at PC + 4 with no instruction lost or duplicated.
- dec_redirect and ex_redirect in the same cycle (targets 0x200 and 0x300) → next fetch at 0x300, fd_valid = 0.
- dec_halt with a request pending → drains, halted = 1, imemREN = 0. A later ex_redirect to 0x40 → halted = 0, fetch at 0x40.
- RST pulse asynchronously mid-DRAIN → outputs return to reset values without waiting for a clock edge; fetch restarts at RESET_PC. An ex_target of 0x103 produces imemaddr 0x100.
